fft_band_peak_extractor: RTL and testbench

Downstream consumer of the radix-2 FFT core's output/DMA port. When the core reports `done`, the block reads bins 0..FFT_LENGTH/2-1 over the DMA read bus and computes an L1 magnitude per bin. It tracks the strongest bin in each of NUM_BANDS equal-width frequency bands and streams one peak record per band over a valid/ready handshake. It then pulses `fin` to return the core to input streaming. These per-frame band peaks feed the fingerprint hashing stage.

---
 rtl/fft_band_peak_extractor.sv | 167 ++++++++++++++++
 tb/tb_fft_band_peak_extractor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_band_peak_extractor.sv
// Scans one half-spectrum from the FFT core's DMA port, keeps the strongest L1-magnitude bin
// per band, and streams one peak record per band before releasing the core with fin.
module fft_band_peak_extractor #(
  parameter int FFT_LENGTH = 1024,
  parameter int FFT_DW     = 16,
  parameter int NUM_BANDS  = 4,
  parameter int FFT_N      = $clog2(FFT_LENGTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fft_done,
  input  logic signed [7:0]            fft_bfpexp,
  output logic                         dmaact,
  output logic [FFT_N-1:0]             dmaa,
  input  logic signed [FFT_DW-1:0]     dmadr_real,
  input  logic signed [FFT_DW-1:0]     dmadr_imag,
  output logic                         fin,
  output logic                         peak_valid,
  input  logic                         peak_ready,
  output logic [$clog2(NUM_BANDS)-1:0] peak_band,
  output logic [FFT_N-2:0]             peak_bin,
  output logic [FFT_DW:0]              peak_mag,
  output logic signed [7:0]            peak_exp,
  output logic                         busy,
  output logic [15:0]                  frame_count
);
  localparam int BAND_W = (FFT_LENGTH / 2) / NUM_BANDS;
  localparam int BB     = $clog2(NUM_BANDS);
  localparam int BIN_W  = FFT_N - 1;
  localparam int MAG_W  = FFT_DW + 1;
  localparam logic [FFT_N-1:0] LAST_ADDR = FFT_N'(FFT_LENGTH / 2 - 1);
  localparam logic [BB-1:0]    LAST_BAND = BB'(NUM_BANDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_DRAIN, S_EMIT, S_FIN, S_WAIT_CLR
  } state_t;

  state_t           state;
  logic             rd_vld;
  logic [BIN_W-1:0] rd_addr;
  logic [BB-1:0]    emit_idx;
  logic [MAG_W-1:0] band_mag [NUM_BANDS];
  logic [BIN_W-1:0] band_bin [NUM_BANDS];

  logic [MAG_W-1:0] ext_re, ext_im, abs_re, abs_im, sample_mag;
  logic [BB-1:0]    sample_band;

  // Sign-extend by one bit first so |-2^(DW-1)| is representable without overflow.
  always_comb begin
    ext_re     = {dmadr_real[FFT_DW-1], dmadr_real};
    ext_im     = {dmadr_imag[FFT_DW-1], dmadr_imag};
    abs_re     = dmadr_real[FFT_DW-1] ? (~ext_re + MAG_W'(1)) : ext_re;
    abs_im     = dmadr_imag[FFT_DW-1] ? (~ext_im + MAG_W'(1)) : ext_im;
    sample_mag = (rd_addr == '0) ? '0 : (abs_re + abs_im);
  end

  assign sample_band = rd_addr[BIN_W-1 -: BB];

  // Record fields come straight from the band registers, which are frozen outside SCAN/DRAIN.
  assign peak_band = emit_idx;
  assign peak_bin  = band_bin[emit_idx];
  assign peak_mag  = band_mag[emit_idx];

  // Handshake: a record transfers on a rising edge with peak_valid && peak_ready; while valid
  // and not ready the fields hold, and valid only drops without a transfer on abort or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dmaact      <= 1'b0;
      dmaa        <= '0;
      fin         <= 1'b0;
      peak_valid  <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
      emit_idx    <= '0;
      peak_exp    <= '0;
      rd_vld      <= 1'b0;
      rd_addr     <= '0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        band_mag[b] <= '0;
        band_bin[b] <= '0;
      end
    end else begin
      rd_vld  <= dmaact;
      rd_addr <= dmaa[BIN_W-1:0];

      // Strict compare: ties keep the earlier (lower) bin.
      if ((state == S_SCAN || state == S_DRAIN) && rd_vld &&
          (sample_mag > band_mag[sample_band])) begin
        band_mag[sample_band] <= sample_mag;
        band_bin[sample_band] <= rd_addr;
      end

      case (state)
        S_IDLE: begin
          if (fft_done) begin
            state    <= S_SCAN;
            busy     <= 1'b1;
            dmaact   <= 1'b1;
            dmaa     <= '0;
            peak_exp <= fft_bfpexp;
            for (int b = 0; b < NUM_BANDS; b++) begin
              band_mag[b] <= '0;
              band_bin[b] <= BIN_W'(b * BAND_W);
            end
          end
        end
        S_SCAN: begin
          if (!fft_done) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            dmaact <= 1'b0;
            dmaa   <= '0;
          end else if (dmaa == LAST_ADDR) begin
            state  <= S_DRAIN;
            dmaact <= 1'b0;
            dmaa   <= '0;
          end else begin
            dmaa <= dmaa + FFT_N'(1);
          end
        end
        S_DRAIN: begin
          if (!fft_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state      <= S_EMIT;
            peak_valid <= 1'b1;
            emit_idx   <= '0;
          end
        end
        S_EMIT: begin
          if (!fft_done) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            peak_valid <= 1'b0;
            emit_idx   <= '0;
          end else if (peak_ready) begin
            if (emit_idx == LAST_BAND) begin
              state       <= S_FIN;
              peak_valid  <= 1'b0;
              emit_idx    <= '0;
              fin         <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end else begin
              emit_idx <= emit_idx + BB'(1);
            end
          end
        end
        S_FIN: begin
          fin   <= 1'b0;
          state <= S_WAIT_CLR;
        end
        S_WAIT_CLR: begin
          if (!fft_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fft_band_peak_extractor.sv
// Directed bench for fft_band_peak_extractor at FFT_LENGTH=64, NUM_BANDS=4 (8 bins per band)
// with a registered DMA memory model and an expected-record queue.
module tb_fft_band_peak_extractor;
  localparam int L = 64, DW = 16, NB = 4, N = 6, HALF = 32, RW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fft_done = 1'b0;
  logic signed [7:0] fft_bfpexp = '0;
  logic              dmaact;
  logic [N-1:0]      dmaa;
  logic signed [DW-1:0] dmadr_real = '0;
  logic signed [DW-1:0] dmadr_imag = '0;
  logic              fin;
  logic              peak_valid;
  logic              peak_ready = 1'b1;
  logic [1:0]        peak_band;
  logic [N-2:0]      peak_bin;
  logic [DW:0]       peak_mag;
  logic signed [7:0] peak_exp;
  logic              busy;
  logic [15:0]       frame_count;

  fft_band_peak_extractor #(.FFT_LENGTH(L), .FFT_DW(DW), .NUM_BANDS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .fft_done(fft_done), .fft_bfpexp(fft_bfpexp),
    .dmaact(dmaact), .dmaa(dmaa), .dmadr_real(dmadr_real), .dmadr_imag(dmadr_imag),
    .fin(fin), .peak_valid(peak_valid), .peak_ready(peak_ready), .peak_band(peak_band),
    .peak_bin(peak_bin), .peak_mag(peak_mag), .peak_exp(peak_exp), .busy(busy),
    .frame_count(frame_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- memory model (data 1 cycle after strobe) ----------------
  logic signed [DW-1:0] mem_re [HALF];
  logic signed [DW-1:0] mem_im [HALF];

  always @(posedge clk) begin
    if (dmaact) begin
      dmadr_real <= mem_re[dmaa[4:0]];
      dmadr_imag <= mem_im[dmaa[4:0]];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_pass = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] cur_rec;
  assign cur_rec = {peak_band, peak_bin, peak_mag, peak_exp};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [RW-1:0] mk_rec(input int band, input int bin, input int mag,
                                           input logic [7:0] e);
    return {2'(band), 5'(bin), 17'(mag), e};
  endfunction

  // ---------------- monitor (samples on the falling edge) ----------------
  int dma_cnt = 0, dma_base = 0, first_dma = 0, first_valid = 0, fin_cyc = 0;
  int fin_cnt = 0, n_xfer = 0, n_stall = 0, valid_cycles = 0;
  bit prev_stall = 0, prev_valid = 0;
  logic [RW-1:0] prev_rec = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) check("stall_hold", 64'({peak_valid, cur_rec}), 64'({1'b1, prev_rec}));
      if (dmaact) begin
        if (dma_cnt == dma_base) first_dma = cyc;
        check("dmaa_seq", 64'(dmaa), 64'(dma_cnt - dma_base));
        dma_cnt++;
      end
      if (peak_valid) valid_cycles++;
      if (peak_valid && !prev_valid) first_valid = cyc;
      if (peak_valid && !peak_ready) n_stall++;
      if (peak_valid && peak_ready) begin
        n_xfer++;
        check("rec_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("rec", 64'(cur_rec), 64'(exp_q.pop_front()));
      end
      if (fin) begin
        fin_cnt++;
        fin_cyc = cyc;
      end
      prev_stall = peak_valid && !peak_ready;
      prev_valid = peak_valid;
      prev_rec   = cur_rec;
    end else begin
      prev_stall = 0;
      prev_valid = 0;
    end
  end

  // ---------------- drivers ----------------
  bit bp_mode = 0;
  always @(posedge clk) begin
    #1;
    peak_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
  end

  int t_done = 0, fin0 = 0, x0 = 0;

  task automatic clear_mem();
    for (int i = 0; i < HALF; i++) begin
      mem_re[i] = '0;
      mem_im[i] = '0;
    end
  endtask

  task automatic load_tone(input logic [7:0] e);
    clear_mem();
    mem_re[13] = 16'sd300;
    mem_im[13] = -16'sd200;
    exp_q.push_back(mk_rec(0, 0, 0, e));
    exp_q.push_back(mk_rec(1, 13, 500, e));
    exp_q.push_back(mk_rec(2, 16, 0, e));
    exp_q.push_back(mk_rec(3, 24, 0, e));
  endtask

  // t_done is the edge index at which the DUT samples fft_done high; the falling-edge
  // monitor at cyc==k observes spec cycle k+1.
  task automatic start_frame(input logic [7:0] e);
    @(posedge clk);
    #1;
    fft_bfpexp = e;
    fft_done   = 1'b1;
    t_done     = cyc + 1;
    dma_base   = dma_cnt;
    fin0       = fin_cnt;
    x0         = n_xfer;
  endtask

  task automatic finish_frame(input bit timed);
    for (int i = 0; i < 400 && fin_cnt == fin0; i++) @(posedge clk);
    #1;
    fft_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("fin_once", 64'(fin_cnt - fin0), 64'd1);
    check("xfer_count", 64'(n_xfer - x0), 64'(NB));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("dma_count", 64'(dma_cnt - dma_base), 64'(HALF));
    check("idle_after", 64'({busy, dmaact, fin, peak_valid}), 64'd0);
    if (timed) begin
      check("lat_dmaact", 64'(first_dma + 1 - t_done), 64'd1);
      check("lat_valid", 64'(first_valid + 1 - t_done), 64'd34);
      check("lat_fin", 64'(fin_cyc + 1 - t_done), 64'd38);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({dmaact, dmaa, fin, peak_valid, busy}), 64'd0);
    check({tag, "_count"}, 64'(frame_count), 64'd0);
    check({tag, "_fields"}, 64'(cur_rec), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // single tone
    load_tone(8'hFD);
    start_frame(8'hFD);
    finish_frame(1);
    check("frame_count_1", 64'(frame_count), 64'd1);

    // backpressure: ready high one cycle in three
    bp_mode = 1;
    load_tone(8'h05);
    start_frame(8'h05);
    finish_frame(0);
    bp_mode = 0;
    check("stalls_seen", 64'(n_stall > 0), 64'd1);
    check("frame_count_2", 64'(frame_count), 64'd2);

    // edge arithmetic: full-scale negative corner beats positive corner; DC ignored
    clear_mem();
    mem_re[0] = 16'sd32767;
    mem_re[5] = -16'sd32768; mem_im[5] = -16'sd32768;
    mem_re[6] = 16'sd32767;  mem_im[6] = 16'sd32767;
    mem_re[31] = -16'sd1;    mem_im[31] = 16'sd2;
    exp_q.push_back(mk_rec(0, 5, 65536, 8'h80));
    exp_q.push_back(mk_rec(1, 8, 0, 8'h80));
    exp_q.push_back(mk_rec(2, 16, 0, 8'h80));
    exp_q.push_back(mk_rec(3, 31, 3, 8'h80));
    start_frame(8'h80);
    finish_frame(1);
    check("frame_count_3", 64'(frame_count), 64'd3);

    // ties keep the lower bin
    clear_mem();
    mem_re[3] = 16'sd60;    mem_im[3] = -16'sd40;
    mem_re[7] = -16'sd100;
    mem_re[20] = 16'sd10;   mem_im[20] = 16'sd10;
    mem_re[21] = -16'sd25;
    exp_q.push_back(mk_rec(0, 3, 100, 8'h7F));
    exp_q.push_back(mk_rec(1, 8, 0, 8'h7F));
    exp_q.push_back(mk_rec(2, 21, 25, 8'h7F));
    exp_q.push_back(mk_rec(3, 24, 0, 8'h7F));
    start_frame(8'h7F);
    finish_frame(1);
    check("frame_count_4", 64'(frame_count), 64'd4);

    // abort by dropping fft_done mid-SCAN
    load_tone(8'h11);
    exp_q.delete();
    start_frame(8'h11);
    repeat (10) @(posedge clk);
    #1;
    fft_done = 1'b0;
    x0 = valid_cycles;
    @(posedge clk);
    #1;
    check("abort_busy", 64'({busy, dmaact}), 64'd0);
    repeat (60) @(posedge clk);
    #1;
    check("abort_no_valid", 64'(valid_cycles - x0), 64'd0);
    check("abort_no_fin", 64'(fin_cnt - fin0), 64'd0);
    check("abort_count", 64'(frame_count), 64'd4);

    // asynchronous reset mid-SCAN, then a clean frame
    start_frame(8'h22);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    fft_done = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_no_fin", 64'(fin_cnt - fin0), 64'd0);
    load_tone(8'h22);
    start_frame(8'h22);
    finish_frame(1);
    check("frame_count_after_rst", 64'(frame_count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
